mem_dcache_ctrl: RTL and testbench
==================================

Name: mem_dcache_ctrl

Overview:
- MEM-stage load/store controller; responder to the EX-stage load/store flag.
- Accepts a pending access (EX_LdStFlag, address in EX_AluData), runs the D-cache request/response handshake, formats store byte lanes and sign/zero-extends load data.
- Pulses Mem_DcacheEN for one cycle at completion, which drops EX_LdStFlag upstream.
- Stalls the pipeline for the whole access.

Parameters:
DATA_WIDTH, 32, scalar data width
ADDR_WIDTH, 32, address width
LD_TYPE_WIDTH, 3, load type code width
ST_TYPE_WIDTH, 2, store type code width

Ports:
clk  in  1  clock
rst_n  in  1  reset
EX_LdStFlag  in  1  access pending from EX
EX_AluData  in  ADDR_WIDTH  effective byte address
EX_StData  in  DATA_WIDTH  store source (rs2)
IDEX_LdType  in  LD_TYPE_WIDTH  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
IDEX_StType  in  ST_TYPE_WIDTH  0 none, 1 SB, 2 SH, 3 SW
Dcache_Ready  in  1  cache accepts request this cycle
Dcache_RdValid  in  1  load data valid
Dcache_RdData  in  DATA_WIDTH  aligned word from cache
Dcache_Req  out  1  request valid
Dcache_Wr  out  1  1 = store
Dcache_Addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
Dcache_WrData  out  DATA_WIDTH  lane-replicated store data
Dcache_ByteEn  out  4  store byte enables
Mem_DcacheEN  out  1  one-cycle completion pulse
Mem_LdData  out  DATA_WIDTH  extended load result
Mem_Stall  out  1  pipeline hold
Mem_Misalign  out  1  one-cycle misaligned-access pulse

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low.
- Reset values: state IDLE; all outputs 0; latched address/type/data cleared.
- States:
  - IDLE: Dcache_Req=0. If EX_LdStFlag=1:
    - Latch address, type and store data.
    - Misaligned: go to ERR.
    - Otherwise: go to REQ.
    - If LdType!=0 and StType!=0 together, treat as the load; the store is ignored.
  - REQ: Dcache_Req=1; Addr/Wr/WrData/ByteEn come from latched values and are held stable until Dcache_Ready=1.
    - On Ready, store: go to DONE.
    - On Ready, load with RdValid in the same cycle: capture data, go to DONE.
    - On Ready, load otherwise: go to WAIT.
  - WAIT: Dcache_Req=0. On Dcache_RdValid, capture extended data into Mem_LdData and go to DONE. No timeout.
  - DONE: Mem_DcacheEN=1 for exactly one cycle; next state IDLE.
  - ERR: Mem_Misalign=1 and Mem_DcacheEN=1 for one cycle. No cache access, Mem_LdData unchanged. Next state IDLE.
- Mem_Stall = (IDLE and EX_LdStFlag) or REQ or WAIT. It is 0 in DONE and ERR, so the pipeline advances on the completion cycle.
- Minimum latency: flag to Mem_DcacheEN is 2 cycles for a store with Ready=1 (IDLE→REQ→DONE). A load with Ready and RdValid in the same cycle is also 2 cycles.
- Misalignment (off = addr[1:0]):
  - LH, LHU, SH: misaligned when off[0]=1.
  - LW, SW: misaligned when off!=0.
  - LB, LBU, SB: never misaligned.
- Store formatting:
  - SB: WrData={4{d[7:0]}}, ByteEn=4'b0001<<off.
  - SH: WrData={2{d[15:0]}}, ByteEn=4'b0011<<off.
  - SW: WrData=d, ByteEn=4'b1111.
  - Loads: ByteEn=0, WrData=0.
- Load extension: select byte RdData[off*8+:8] or halfword RdData[off*8+:16].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: whole word.
- Mem_LdData holds its value until the next completed load or reset.
- Dcache_RdValid is ignored outside REQ and WAIT, including stale responses after reset.
- Reset mid-access (REQ or WAIT): return to IDLE next edge with Req=0. No Mem_DcacheEN pulse.

Test Plan:
- SW, addr 0x1000_0008, data 0xDEADBEEF, Ready=1 in first REQ cycle → Req=1 one cycle, Addr=0x1000_0008, ByteEn=1111, WrData=0xDEADBEEF; Mem_DcacheEN high at cycle 2; Stall high for cycles 0–1.
- LB, addr 0x2000_0003, RdData=0x80AB_CDEF after 3 WAIT cycles → Addr=0x2000_0000, Mem_LdData=0xFFFF_FF80, single EN pulse.
- LHU, addr 0x2000_0002, RdData=0x8001_1234 → Mem_LdData=0x0000_8001. SH at the same address, data 0x0000_BEEF → ByteEn=1100, WrData=0xBEEF_BEEF.
- Misaligned LW at 0x3000_0002 → no Req; Mem_Misalign and Mem_DcacheEN pulse together at cycle 1; Mem_LdData unchanged.
- SW with Ready held 0 for 5 cycles → Req, Addr and WrData stable for all 6 cycles; Stall held; EN only after Ready.
- LW, rst_n=0 asserted in WAIT, RdValid arrives after reset → state IDLE, Req=0, Mem_LdData=0, no EN pulse.

Source files
------------

// File: rtl/mem_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dcache_ctrl
// Brief    : MEM-stage load/store controller. Takes a pending access from EX,
//            runs the D-cache request/response handshake, formats store byte
//            lanes, sign/zero-extends load data and pulses a one-cycle
//            completion strobe that retires the access upstream.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dcache_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int LD_TYPE_WIDTH = 3,
    parameter int ST_TYPE_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     EX_LdStFlag,
    input  logic [ADDR_WIDTH-1:0]    EX_AluData,
    input  logic [DATA_WIDTH-1:0]    EX_StData,
    input  logic [LD_TYPE_WIDTH-1:0] IDEX_LdType,
    input  logic [ST_TYPE_WIDTH-1:0] IDEX_StType,
    input  logic                     Dcache_Ready,
    input  logic                     Dcache_RdValid,
    input  logic [DATA_WIDTH-1:0]    Dcache_RdData,
    output logic                     Dcache_Req,
    output logic                     Dcache_Wr,
    output logic [ADDR_WIDTH-1:0]    Dcache_Addr,
    output logic [DATA_WIDTH-1:0]    Dcache_WrData,
    output logic [3:0]               Dcache_ByteEn,
    output logic                     Mem_DcacheEN,
    output logic [DATA_WIDTH-1:0]    Mem_LdData,
    output logic                     Mem_Stall,
    output logic                     Mem_Misalign
);

    // ------------------------------------------------------------------------
    // State and access-type encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_DONE = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;

    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_NONE = LD_TYPE_WIDTH'(0);
    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_LB   = LD_TYPE_WIDTH'(1);
    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_LH   = LD_TYPE_WIDTH'(2);
    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_LW   = LD_TYPE_WIDTH'(3);
    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_LBU  = LD_TYPE_WIDTH'(4);
    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_LHU  = LD_TYPE_WIDTH'(5);

    localparam logic [ST_TYPE_WIDTH-1:0] c_ST_NONE = ST_TYPE_WIDTH'(0);
    localparam logic [ST_TYPE_WIDTH-1:0] c_ST_SB   = ST_TYPE_WIDTH'(1);
    localparam logic [ST_TYPE_WIDTH-1:0] c_ST_SH   = ST_TYPE_WIDTH'(2);
    localparam logic [ST_TYPE_WIDTH-1:0] c_ST_SW   = ST_TYPE_WIDTH'(3);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [2:0]               r_state;
    logic [2:0]               w_next_state;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [LD_TYPE_WIDTH-1:0] r_ld_type;
    logic [ST_TYPE_WIDTH-1:0] r_st_type;
    logic [DATA_WIDTH-1:0]    r_st_data;
    logic [DATA_WIDTH-1:0]    r_ld_data;

    logic                     w_latch;
    logic                     w_capture;
    logic                     w_misalign_in;
    logic [ST_TYPE_WIDTH-1:0] w_st_type_in;
    logic [1:0]               w_off_in;
    logic [1:0]               w_off;
    logic                     w_is_load;
    logic [DATA_WIDTH-1:0]    w_wr_data;
    logic [3:0]               w_byte_en;
    logic [7:0]               w_rd_byte;
    logic [15:0]              w_rd_half;
    logic [DATA_WIDTH-1:0]    w_ld_ext;

    assign w_off_in  = EX_AluData[1:0];
    assign w_off     = r_addr[1:0];
    assign w_is_load = (r_ld_type != c_LD_NONE);

    // A load takes precedence over a simultaneous store: the store type is
    // squashed before it is latched so downstream logic sees a pure load.
    assign w_st_type_in = (IDEX_LdType != c_LD_NONE) ? c_ST_NONE : IDEX_StType;

    // Alignment check on the incoming access, using the effective type
    always_comb begin
        w_misalign_in = 1'b0;
        if (IDEX_LdType != c_LD_NONE) begin
            case (IDEX_LdType)
                c_LD_LH, c_LD_LHU: w_misalign_in = w_off_in[0];
                c_LD_LW:           w_misalign_in = (w_off_in != 2'b00);
                default:           w_misalign_in = 1'b0;
            endcase
        end else begin
            case (IDEX_StType)
                c_ST_SH: w_misalign_in = w_off_in[0];
                c_ST_SW: w_misalign_in = (w_off_in != 2'b00);
                default: w_misalign_in = 1'b0;
            endcase
        end
    end

    // Store lane replication and byte enables from the latched access
    always_comb begin
        w_wr_data = '0;
        w_byte_en = 4'b0000;
        case (r_st_type)
            c_ST_SB: begin
                w_wr_data = {(DATA_WIDTH/8){r_st_data[7:0]}};
                w_byte_en = 4'b0001 << w_off;
            end
            c_ST_SH: begin
                w_wr_data = {(DATA_WIDTH/16){r_st_data[15:0]}};
                w_byte_en = 4'b0011 << w_off;
            end
            c_ST_SW: begin
                w_wr_data = r_st_data;
                w_byte_en = 4'b1111;
            end
            default: begin
                w_wr_data = '0;
                w_byte_en = 4'b0000;
            end
        endcase
    end

    // Lane selection; halfwords are always even-aligned here, so only off[1]
    // chooses the half.
    assign w_rd_byte = Dcache_RdData[{w_off, 3'b000} +: 8];
    assign w_rd_half = Dcache_RdData[{w_off[1], 4'b0000} +: 16];

    // Sign/zero extension of the selected lane by load type
    always_comb begin
        w_ld_ext = Dcache_RdData;
        case (r_ld_type)
            c_LD_LB:  w_ld_ext = {{(DATA_WIDTH-8){w_rd_byte[7]}}, w_rd_byte};
            c_LD_LBU: w_ld_ext = {{(DATA_WIDTH-8){1'b0}}, w_rd_byte};
            c_LD_LH:  w_ld_ext = {{(DATA_WIDTH-16){w_rd_half[15]}}, w_rd_half};
            c_LD_LHU: w_ld_ext = {{(DATA_WIDTH-16){1'b0}}, w_rd_half};
            default:  w_ld_ext = Dcache_RdData;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Access latch on acceptance and load-result capture on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_ld_type <= c_LD_NONE;
            r_st_type <= c_ST_NONE;
            r_st_data <= '0;
            r_ld_data <= '0;
        end else begin
            if (w_latch) begin
                r_addr    <= EX_AluData;
                r_ld_type <= IDEX_LdType;
                r_st_type <= w_st_type_in;
                r_st_data <= EX_StData;
            end
            if (w_capture) begin
                r_ld_data <= w_ld_ext;
            end
        end
    end

    assign Mem_LdData = r_ld_data;

    // Next-state and handshake outputs; cache-side buses are only driven
    // while a request is on the bus and are zero otherwise.
    always_comb begin
        w_next_state  = r_state;
        w_latch       = 1'b0;
        w_capture     = 1'b0;
        Dcache_Req    = 1'b0;
        Dcache_Wr     = 1'b0;
        Dcache_Addr   = '0;
        Dcache_WrData = '0;
        Dcache_ByteEn = 4'b0000;
        Mem_DcacheEN  = 1'b0;
        Mem_Misalign  = 1'b0;
        Mem_Stall     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (EX_LdStFlag) begin
                    Mem_Stall = 1'b1;
                    w_latch   = 1'b1;
                    if (w_misalign_in) begin
                        w_next_state = c_ST_ERR;
                    end else if ((IDEX_LdType == c_LD_NONE) && (IDEX_StType == c_ST_NONE)) begin
                        // Flag without an access type: retire without touching the cache
                        w_next_state = c_ST_DONE;
                    end else begin
                        w_next_state = c_ST_REQ;
                    end
                end
            end
            c_ST_REQ: begin
                Mem_Stall     = 1'b1;
                Dcache_Req    = 1'b1;
                Dcache_Wr     = ~w_is_load;
                Dcache_Addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                Dcache_WrData = w_wr_data;
                Dcache_ByteEn = w_byte_en;
                if (Dcache_Ready) begin
                    if (!w_is_load) begin
                        w_next_state = c_ST_DONE;
                    end else if (Dcache_RdValid) begin
                        w_capture    = 1'b1;
                        w_next_state = c_ST_DONE;
                    end else begin
                        w_next_state = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                Mem_Stall = 1'b1;
                if (Dcache_RdValid) begin
                    w_capture    = 1'b1;
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                Mem_DcacheEN = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            c_ST_ERR: begin
                Mem_DcacheEN = 1'b1;
                Mem_Misalign = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dcache_ctrl
// Brief    : Scoreboard bench for mem_dcache_ctrl. Stimulus pushes the
//            expected cache request and completion; a negedge monitor pops
//            and compares whenever the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_dcache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        EX_LdStFlag;
    logic [31:0] EX_AluData;
    logic [31:0] EX_StData;
    logic [2:0]  IDEX_LdType;
    logic [1:0]  IDEX_StType;
    logic        Dcache_Ready;
    logic        Dcache_RdValid;
    logic [31:0] Dcache_RdData;
    logic        Dcache_Req;
    logic        Dcache_Wr;
    logic [31:0] Dcache_Addr;
    logic [31:0] Dcache_WrData;
    logic [3:0]  Dcache_ByteEn;
    logic        Mem_DcacheEN;
    logic [31:0] Mem_LdData;
    logic        Mem_Stall;
    logic        Mem_Misalign;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  be;
    } req_t;

    typedef struct packed {
        logic        mis;
        logic [31:0] ld;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];
    cmp_t r_mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_dcache_ctrl #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .LD_TYPE_WIDTH(3),
        .ST_TYPE_WIDTH(2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .EX_LdStFlag   (EX_LdStFlag),
        .EX_AluData    (EX_AluData),
        .EX_StData     (EX_StData),
        .IDEX_LdType   (IDEX_LdType),
        .IDEX_StType   (IDEX_StType),
        .Dcache_Ready  (Dcache_Ready),
        .Dcache_RdValid(Dcache_RdValid),
        .Dcache_RdData (Dcache_RdData),
        .Dcache_Req    (Dcache_Req),
        .Dcache_Wr     (Dcache_Wr),
        .Dcache_Addr   (Dcache_Addr),
        .Dcache_WrData (Dcache_WrData),
        .Dcache_ByteEn (Dcache_ByteEn),
        .Mem_DcacheEN  (Mem_DcacheEN),
        .Mem_LdData    (Mem_LdData),
        .Mem_Stall     (Mem_Stall),
        .Mem_Misalign  (Mem_Misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented request cycle against the queue head
    // (so a stalled request must stay stable) and every completion pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (Dcache_Req) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h expected no request", Dcache_Addr);
                end else begin
                    check32("req_addr",   Dcache_Addr,         req_q[0].addr);
                    check32("req_wr",     32'(Dcache_Wr),      32'(req_q[0].wr));
                    check32("req_wrdata", Dcache_WrData,       req_q[0].wd);
                    check32("req_byteen", 32'(Dcache_ByteEn),  32'(req_q[0].be));
                    if (Dcache_Ready) void'(req_q.pop_front());
                end
            end
            if (Mem_DcacheEN) begin
                if (cmp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en: got EN=1 expected no completion");
                end else begin
                    r_mon_e = cmp_q.pop_front();
                    check32("cmp_misalign", 32'(Mem_Misalign), 32'(r_mon_e.mis));
                    check32("cmp_lddata",   Mem_LdData,        r_mon_e.ld);
                end
            end else if (Mem_Misalign) begin
                checks++;
                errors++;
                $display("FAIL misalign_without_en: got Misalign=1 expected 0");
            end
        end
    end

    // One access from flag assertion (cycle 0) until the completion pulse.
    // Ready is high from ready_cyc on; RdValid is high only in cycle rv_cyc.
    task automatic access(input string name,
                          input logic [2:0] ld, input logic [1:0] st,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int ready_cyc, input int rv_cyc, input logic [31:0] rdata,
                          input int exp_lat, input bit exp_req,
                          input logic [31:0] exp_addr, input logic exp_wr,
                          input logic [31:0] exp_wd, input logic [3:0] exp_be,
                          input logic exp_mis, input logic [31:0] exp_ld);
        bit done = 1'b0;
        if (exp_req) req_q.push_back('{addr: exp_addr, wr: exp_wr, wd: exp_wd, be: exp_be});
        cmp_q.push_back('{mis: exp_mis, ld: exp_ld});
        @(posedge clk); #1;
        EX_LdStFlag   = 1'b1;
        EX_AluData    = addr;
        EX_StData     = sdata;
        IDEX_LdType   = ld;
        IDEX_StType   = st;
        Dcache_RdData = rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            Dcache_Ready   = (c >= ready_cyc);
            Dcache_RdValid = (c == rv_cyc);
            @(negedge clk);
            if (Mem_DcacheEN) begin
                done = 1'b1;
                check32({name, "_latency"}, 32'(c), 32'(exp_lat));
                check32({name, "_stall_done"}, 32'(Mem_Stall), 32'd0);
            end else begin
                check32({name, "_stall_busy"}, 32'(Mem_Stall), 32'd1);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no EN in 40 cycles expected EN at cycle %0d", name, exp_lat);
        end
        EX_LdStFlag    = 1'b0;
        IDEX_LdType    = 3'd0;
        IDEX_StType    = 2'd0;
        Dcache_Ready   = 1'b0;
        Dcache_RdValid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        EX_LdStFlag    = 1'b0;
        EX_AluData     = 32'h0;
        EX_StData      = 32'h0;
        IDEX_LdType    = 3'd0;
        IDEX_StType    = 2'd0;
        Dcache_Ready   = 1'b0;
        Dcache_RdValid = 1'b1;   // stale response during reset must be ignored
        Dcache_RdData  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_req",    32'(Dcache_Req),    32'd0);
        check32("rst_en",     32'(Mem_DcacheEN),  32'd0);
        check32("rst_mis",    32'(Mem_Misalign),  32'd0);
        check32("rst_stall",  32'(Mem_Stall),     32'd0);
        check32("rst_lddata", Mem_LdData,         32'h0);
        check32("rst_addr",   Dcache_Addr,        32'h0);
        check32("rst_byteen", 32'(Dcache_ByteEn), 32'd0);
        check32("rst_wrdata", Dcache_WrData,      32'h0);
        @(posedge clk); #1;
        rst_n          = 1'b1;
        Dcache_RdValid = 1'b0;

        //     name         ld    st    addr           sdata          rdy rv  rdata          lat req exp_addr       wr    wd             be       mis   ld
        access("sw",        3'd0, 2'd3, 32'h1000_0008, 32'hDEAD_BEEF, 1, -1, 32'h0,         2, 1, 32'h1000_0008, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000);
        access("lb_wait",   3'd1, 2'd0, 32'h2000_0003, 32'h0,         1,  5, 32'h80AB_CDEF, 6, 1, 32'h2000_0000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'hFFFF_FF80);
        access("lhu",       3'd5, 2'd0, 32'h2000_0002, 32'h0,         1,  1, 32'h8001_1234, 2, 1, 32'h2000_0000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0000_8001);
        access("sh",        3'd0, 2'd2, 32'h2000_0002, 32'h0000_BEEF, 1, -1, 32'h0,         2, 1, 32'h2000_0000, 1'b1, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'h0000_8001);
        access("lw_mis",    3'd3, 2'd0, 32'h3000_0002, 32'h0,         0, -1, 32'h0,         1, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 1'b1, 32'h0000_8001);
        access("sw_stall",  3'd0, 2'd3, 32'h1000_0010, 32'h1234_5678, 6, -1, 32'h0,         7, 1, 32'h1000_0010, 1'b1, 32'h1234_5678, 4'b1111, 1'b0, 32'h0000_8001);
        access("lh_sext",   3'd2, 2'd0, 32'h4000_0002, 32'h0,         1,  3, 32'h9ABC_0000, 4, 1, 32'h4000_0000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'hFFFF_9ABC);
        access("lbu",       3'd4, 2'd0, 32'h4000_0001, 32'h0,         2,  2, 32'h0000_F100, 3, 1, 32'h4000_0000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0000_00F1);
        access("sb",        3'd0, 2'd1, 32'h5000_0001, 32'hFFFF_FF5A, 1, -1, 32'h0,         2, 1, 32'h5000_0000, 1'b1, 32'h5A5A_5A5A, 4'b0010, 1'b0, 32'h0000_00F1);
        access("lw",        3'd3, 2'd0, 32'h6000_0004, 32'h0,         1,  1, 32'hCAFE_F00D, 2, 1, 32'h6000_0004, 1'b0, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D);
        access("ld_and_st", 3'd1, 2'd1, 32'h7000_0000, 32'h1111_1111, 1,  1, 32'hAAAA_AA7F, 2, 1, 32'h7000_0000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0000_007F);
        access("sh_mis",    3'd0, 2'd2, 32'h5000_0003, 32'h0,         0, -1, 32'h0,         1, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 1'b1, 32'h0000_007F);
        access("sw_mis",    3'd0, 2'd3, 32'h5000_0001, 32'h0,         0, -1, 32'h0,         1, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 1'b1, 32'h0000_007F);

        // LW aborted by reset while waiting; the late response must be dropped
        req_q.push_back('{addr: 32'h8000_0000, wr: 1'b0, wd: 32'h0, be: 4'b0000});
        @(posedge clk); #1;
        EX_LdStFlag  = 1'b1;
        EX_AluData   = 32'h8000_0000;
        IDEX_LdType  = 3'd3;
        @(posedge clk); #1;
        Dcache_Ready = 1'b1;
        @(posedge clk); #1;
        Dcache_Ready = 1'b0;
        EX_LdStFlag  = 1'b0;
        IDEX_LdType  = 3'd0;
        @(negedge clk);
        check32("wait_stall", 32'(Mem_Stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n          = 1'b1;
        Dcache_RdValid = 1'b1;
        Dcache_RdData  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("abort_req",    32'(Dcache_Req),   32'd0);
            check32("abort_en",     32'(Mem_DcacheEN), 32'd0);
            check32("abort_stall",  32'(Mem_Stall),    32'd0);
            check32("abort_lddata", Mem_LdData,        32'h0);
            @(posedge clk); #1;
        end
        Dcache_RdValid = 1'b0;
        repeat (2) @(posedge clk);

        check32("req_q_empty", 32'(req_q.size()), 32'd0);
        check32("cmp_q_empty", 32'(cmp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
